aclu_sequencer: RTL
===================

# aclu_sequencer

Program sequencer that drives the accumulator/ALU datapath (`MAIN`) from a byte-wide program ROM. It fetches and decodes instructions and issues ENABLE/AC1/AC2/SEL/operand controls to the datapath. It captures the datapath's C/ZERO flags and executes conditional jumps on them. It is the initiator of the datapath's control interface, replacing hand-driven stimulus.

## Interface
- `RESET_ADDR`, default 8'h00: PC value loaded on reset.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: reset, synchronous, active-low.
- `RUN` in 1: run enable; sampled only in FETCH.
- `ROM_ADDR` out 8: program address, always equal to the PC register.
- `ROM_DATA` in 8: ROM byte, valid one cycle after `ROM_ADDR` (synchronous ROM).
- `C` in 1: datapath carry flag.
- `ZERO` in 1: datapath zero flag.
- `IN` out 4: operand nibble to the datapath input buffer.
- `ENABLE` out 1: datapath input-buffer enable.
- `AC1` out 1: accumulator load enable.
- `AC2` out 1: output-buffer enable.
- `SEL` out 3: ALU function select.
- `HALTED` out 1: high while in HALT.

## Operation
- Instruction byte: [7:4] opcode, [3:0] immediate k. Jumps take two bytes; the second byte is the absolute target.
- Opcodes:
  - 0 NOP.
  - 1 LDI: SEL=PASS.
  - 2 ADDI: SEL=ADD.
  - 3 SUBI: SEL=SUB.
  - 4 ANDI: SEL=AND.
  - 5 ORI: SEL=OR.
  - 6 CMPI: SEL=SUB, AC1=0.
  - 7 OUT: AC2=1.
  - 8 JMP.
  - 9 JC.
  - 10 JZ.
  - 11 JNZ.
  - 15 HALT.
  - 12–14: treated as NOP.
- ALU ops (1–5): in EXEC, `IN`=k, ENABLE=1, AC1=1, SEL per table.
- CMPI: in EXEC, ENABLE=1, AC1=0, SEL=SUB.
- Flag capture: at the end of EXEC of opcodes 1–6, internal FC<=C and FZ<=ZERO. No other instruction alters FC/FZ.
- Jump conditions:
  - JMP: always taken.
  - JC: taken when FC=1.
  - JZ: taken when FZ=1.
  - JNZ: taken when FZ=0.
- FSM states FETCH, DECODE, EXEC, JTGT, HALT:
  - FETCH: if RUN=1, go to DECODE; otherwise stay in FETCH.
  - DECODE: IR<=ROM_DATA; PC<=PC+1; go to EXEC.
  - EXEC: drive controls from IR.
    - Opcodes 8–11: go to JTGT.
    - Opcode 15: go to HALT.
    - Otherwise: go to FETCH.
  - JTGT: PC<=ROM_DATA if taken, else PC<=PC+1. Go to FETCH.
  - HALT: stay until reset; HALTED=1.
- ENABLE, AC1, AC2, SEL and `IN` are nonzero only in EXEC. All are 0 in every other state.
- Reset values:
  - PC=RESET_ADDR, state=FETCH.
  - IR=0, FC=FZ=0.
  - All outputs 0; `ROM_ADDR`=RESET_ADDR.
- Boundary conditions:
  - PC wraps 8'hFF→8'h00, including the operand-byte increment in JTGT.
  - Reset asserted in any state, mid-jump included, wins on that edge. No partial update survives.
  - RUN deasserted mid-instruction has no effect; the instruction completes and the sequencer stops in FETCH.
  - A jump target equal to its own opcode address is legal (tight loop).

## Timing
- 1-byte instruction: 3 cycles (FETCH, DECODE, EXEC). Jump: 4 cycles.
- Datapath controls are asserted for exactly one cycle per instruction and are decoded from registered state and IR (glitch-free).
- `ROM_ADDR` in EXEC equals the address of the operand byte; the ROM returns that byte in JTGT.
- C/ZERO must be valid combinationally within the EXEC cycle; they are sampled at its closing edge.
- After RST returns high with RUN=1, the first `ROM_ADDR` read is at cycle 0. The first EXEC occurs at cycle 2.

## Structure
- Package `aclu_pkg` holds:
  - Opcode constants (4-bit).
  - SEL constants: PASS=3'b000, ADD=3'b010, SUB=3'b011, AND=3'b100, OR=3'b001.
  - The FSM state encoding.
- Single module; no sub-module needed. Condition evaluation stays inline.
- The bench pairs `aclu_sequencer` with `MAIN` and a behavioural synchronous ROM.

## Test plan
- Reset and RUN gating: hold RST=0 for 2 cycles, then RUN=0 → `ROM_ADDR`=00 and all controls 0 indefinitely. Raise RUN → first EXEC 2 cycles later.
- LDI 2; ADDI 3; OUT (bytes 12,23,70) → EXEC controls in order:
  - IN=2, SEL=000, AC1=1.
  - IN=3, SEL=010, AC1=1.
  - AC2=1 with datapath OUT=5.
  - Instruction spacing: 3 cycles.
- LDI 0; CMPI 0; JZ 20 (bytes 10,60,A0,20) → FZ=1, PC=20 after JTGT. Repeat with LDI 1: no jump, PC=04.
- Carry path: LDI F; ADDI 1; JC 40 → FC=1, PC=40. JNZ after a zero result → not taken.
- Wrap and HALT: RESET_ADDR=FE, ROM[FE]=00, ROM[FF]=00, ROM[00]=F0 → PC wraps to 00. HALTED=1 and stays; controls remain 0.
- Reset mid-jump: assert RST=0 in JTGT → next edge PC=RESET_ADDR, state FETCH, FC=FZ=0.

Source files
------------

// File: rtl/aclu_pkg.sv
// aclu_pkg: opcode, ALU select and FSM state encodings shared by the aclu sequencer.
package aclu_pkg;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_ORI  = 4'd5;
    localparam logic [3:0] OP_CMPI = 4'd6;
    localparam logic [3:0] OP_OUT  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JC   = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_JNZ  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SUB  = 3'b011;
    localparam logic [2:0] SEL_AND  = 3'b100;
    localparam logic [2:0] SEL_OR   = 3'b001;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_JTGT, S_HALT} state_t;

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        return op == OP_ADDI ? SEL_ADD : op == OP_SUBI ? SEL_SUB :
               op == OP_ANDI ? SEL_AND : op == OP_ORI  ? SEL_OR  : SEL_PASS;
    endfunction
endpackage

// File: rtl/aclu_sequencer.sv
// aclu_sequencer: fetch/decode/execute sequencer driving the accumulator/ALU datapath
// from a synchronous byte-wide program ROM, with flag-conditional jumps.
module aclu_sequencer
    import aclu_pkg::*;
#(
    parameter logic [7:0] RESET_ADDR = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    output logic [7:0] o_rom_addr,
    input  logic [7:0] i_rom_data,
    input  logic       i_c,
    input  logic       i_zero,
    output logic [3:0] o_in,
    output logic       o_enable,
    output logic       o_ac1,
    output logic       o_ac2,
    output logic [2:0] o_sel,
    output logic       o_halted
);
    state_t     r_state;
    logic [7:0] r_pc;
    logic [3:0] r_ir;
    logic [3:0] r_in;
    logic [2:0] r_sel;
    logic       r_fc, r_fz, r_enable, r_ac1, r_ac2, r_halted;
    logic [3:0] w_dec_op;
    logic       w_dec_alu, w_dec_cmp, w_flags, w_jump, w_taken;

    assign w_dec_op  = i_rom_data[7:4];
    assign w_dec_alu = w_dec_op >= OP_LDI && w_dec_op <= OP_ORI;
    assign w_dec_cmp = w_dec_op == OP_CMPI;
    assign w_flags   = r_ir >= OP_LDI && r_ir <= OP_CMPI;
    assign w_jump    = r_ir >= OP_JMP && r_ir <= OP_JNZ;
    assign w_taken   = r_ir == OP_JMP || (r_ir == OP_JC && r_fc) ||
                       (r_ir == OP_JZ && r_fz) || (r_ir == OP_JNZ && !r_fz);

    // Controls are loaded while decoding so they are clean register outputs for exactly the EXEC cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_ADDR;
            r_ir     <= OP_NOP;
            r_fc     <= 1'b0;
            r_fz     <= 1'b0;
            r_in     <= 4'd0;
            r_sel    <= SEL_PASS;
            r_enable <= 1'b0;
            r_ac1    <= 1'b0;
            r_ac2    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_in     <= 4'd0;
            r_sel    <= SEL_PASS;
            r_enable <= 1'b0;
            r_ac1    <= 1'b0;
            r_ac2    <= 1'b0;
            case (r_state)
                S_FETCH: r_state <= i_run ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_ir     <= w_dec_op;
                    r_pc     <= r_pc + 8'd1;
                    r_in     <= (w_dec_alu || w_dec_cmp) ? i_rom_data[3:0] : 4'd0;
                    r_sel    <= w_dec_alu ? alu_sel(w_dec_op) : w_dec_cmp ? SEL_SUB : SEL_PASS;
                    r_enable <= w_dec_alu || w_dec_cmp;
                    r_ac1    <= w_dec_alu;
                    r_ac2    <= w_dec_op == OP_OUT;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_flags) begin
                        r_fc <= i_c;
                        r_fz <= i_zero;
                    end
                    r_halted <= r_ir == OP_HALT;
                    r_state  <= w_jump ? S_JTGT : r_ir == OP_HALT ? S_HALT : S_FETCH;
                end
                S_JTGT: begin
                    r_pc    <= w_taken ? i_rom_data : r_pc + 8'd1;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign o_rom_addr = r_pc;
    assign o_in       = r_in;
    assign o_sel      = r_sel;
    assign o_enable   = r_enable;
    assign o_ac1      = r_ac1;
    assign o_ac2      = r_ac2;
    assign o_halted   = r_halted;
endmodule
